// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divider and data width.
package uart_pkg;

  localparam int unsigned BAUD_DIV_DEF = 434;
  localparam int unsigned BIT_CNT      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter with enable and sync clear; tick on the last cycle of each bit,
// pre_tick one cycle earlier. Shared with the future RX block.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_c,
  output logic pre_tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c     = en && (cnt == CNT_W'(DIV - 1));
  assign pre_tick_c = en && (cnt == CNT_W'(DIV - 2));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: pops bytes from a 1-cycle-latency FIFO and frames them onto txd.
// Optional even parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEF,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_urttx_empty,
  input  logic [7:0] i_urttx_rd_dat,
  output logic       o_urttx_rd_en,
  output logic       o_uart_txd,
  output logic       o_tx_busy,
  output logic       o_byte_done
);

  if (BAUD_DIV < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
    $error("uart_tx_ser: BAUD_DIV must be >= 2 and STOP_BITS must be 1 or 2");
  end

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       baud_en_c;
  logic       tick_c;
  logic       pre_tick_c;
  logic       last_stop_c;
`ifdef UART_TX_PARITY_EN
  logic       parity_bit;
`endif

  assign baud_en_c   = state inside {START, DATA, PARITY, STOP};
  assign last_stop_c = (bit_cnt == 3'(STOP_BITS - 1));

  uart_baud_tick #(.DIV(BAUD_DIV)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (baud_en_c),
    .clr        (!baud_en_c),
    .tick_c     (tick_c),
    .pre_tick_c (pre_tick_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      o_urttx_rd_en <= 1'b0;
      o_uart_txd    <= 1'b1;
      o_tx_busy     <= 1'b0;
      o_byte_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      o_urttx_rd_en <= 1'b0;
      o_byte_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_urttx_empty) begin
            state         <= FETCH;
            o_urttx_rd_en <= 1'b1;
            o_tx_busy     <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shreg      <= i_urttx_rd_dat;
          bit_cnt    <= '0;
          o_uart_txd <= 1'b0;
          state      <= START;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^i_urttx_rd_dat;
`endif
        end
        START: begin
          if (tick_c) begin
            o_uart_txd <= shreg[0];
            state      <= DATA;
          end
        end
        DATA: begin
          if (tick_c) begin
            shreg <= shreg >> 1;
            if (bit_cnt == 3'(BIT_CNT - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              o_uart_txd <= parity_bit;
              state      <= PARITY;
`else
              o_uart_txd <= 1'b1;
              state      <= STOP;
`endif
            end else begin
              bit_cnt    <= bit_cnt + 3'd1;
              o_uart_txd <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick_c) begin
            o_uart_txd <= 1'b1;
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          // byte_done is registered, so it is armed one cycle before the final tick
          if (last_stop_c && pre_tick_c) o_byte_done <= 1'b1;
          if (tick_c) begin
            if (last_stop_c) begin
              bit_cnt   <= '0;
              o_tx_busy <= 1'b0;
              state     <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
